m_fifo36_to_ll8: RTL and testbench
==================================

Name: m_fifo36_to_ll8

Overview:
- Width converter directly downstream of the 2-clock cascade FIFO, in the read-clock domain.
- Consumes 36-bit FIFO words over the src_rdy/dst_rdy handshake and emits an 8-bit, byte-serial framed stream toward the GEMAC TX path.
- Holds one word, serialises it MSB-byte-first, and trims the final word of a frame using its occupancy field.
- Sustains 1 byte/clk with no bubble between words.

Parameters:
- BYTE_ORDER_BE, 1, 1 = byte 0 is datain[31:24] (big-endian); 0 = byte 0 is datain[7:0].

Ports:
- clk  in  1  single clock (FIFO read clock).
- reset  in  1  asynchronous, active-low reset.
- datain  in  36  FIFO word: [31:0] data, [32] SOF, [33] EOF, [35:34] occ (0 = 4 bytes valid, 1..3 = bytes valid in the EOF word).
- src_rdy_i  in  1  upstream word valid.
- dst_rdy_o  out  1  this block accepts the word this cycle.
- ll_data  out  8  output byte.
- ll_sof  out  1  first byte of frame.
- ll_eof  out  1  last byte of frame.
- ll_src_rdy  out  1  output byte valid.
- ll_dst_rdy  in  1  downstream accepts the byte.
- frame_err  out  1  sticky framing-error flag; constant 0 without the optional feature.

Behaviour:
- Transfer rules: a word transfers when src_rdy_i & dst_rdy_o at a clk edge; a byte transfers when ll_src_rdy & ll_dst_rdy.
- State: hold register (36 b), valid bit, byte index idx[1:0], last index lst[1:0].
- FSM has two states:
  - EMPTY: valid=0, dst_rdy_o=1, ll_src_rdy=0.
  - FULL: valid=1, ll_src_rdy=1.
- Capturing a word sets idx=0. lst = 3 if EOF=0 or occ=0, otherwise occ-1.
- dst_rdy_o = !valid | (ll_dst_rdy & idx==lst). This allows back-to-back words with no idle cycle.
- FULL byte accepted with idx<lst: idx increments.
- FULL byte accepted with idx==lst: load a new word if one transfers in the same cycle, otherwise go to EMPTY.
- Latency: a word accepted at edge N presents byte 0 from cycle N+1 (registered hold, combinational byte mux).
- Output flags:
  - ll_sof = hold SOF & idx==0.
  - ll_eof = hold EOF & idx==lst.
- Words with EOF=0 always emit 4 bytes; occ is ignored.
- A single word with both SOF and EOF is a 1..4-byte frame. With occ=1 it emits one byte with ll_sof=ll_eof=1.
- Output stall: ll_dst_rdy=0 freezes ll_data/ll_sof/ll_eof/idx and keeps ll_src_rdy=1. Output must stay stable while stalled.
- Reset (async assert, sync deassert upstream) forces:
  - valid=0, idx=0, lst=3, hold=0, frame_err=0.
  - Outputs ll_src_rdy=0, ll_sof=0, ll_eof=0, ll_data=0, dst_rdy_o=1 after deassert.
- Reset mid-frame discards the partial word. There is no recovery beyond the next SOF.

Optional Feature:
- Macro: FIFO36_LL8_FRAMECHK_EN.
- When defined, an in_frame bit is tracked: set on an accepted SOF word, cleared on an accepted EOF word.
- A word accepted with SOF=0 while !in_frame is consumed but not emitted (dropped, valid stays 0) and sets frame_err.
- A SOF word while in_frame sets frame_err. The new frame is emitted normally; the old frame is left without EOF.
- frame_err is cleared only by reset.
- When not defined, no check is made, every word is emitted, and frame_err is tied 0.

Decomposition:
- Shared package fifo36_pkg holds:
  - Bit-position constants: SOF_BIT=32, EOF_BIT=33, OCC_LSB=34, OCC_W=2.
  - A helper function occ_to_last(eof, occ) returning the 2-bit last index.
- No sub-module; byte mux and FSM are in one module.

Test Plan:
- Single frame, words 0x1_11223344 (SOF), 0x2_55667788 (EOF, occ=0), ll_dst_rdy=1 -> bytes 11..88 on 8 consecutive cycles; ll_sof on 0x11, ll_eof on 0x88; dst_rdy_o high on cycles 0 and 4 only.
- EOF word occ=1, word 0x7_AABBCCDD (SOF+EOF) -> exactly one byte 0xAA with ll_sof=ll_eof=1, then ll_src_rdy=0.
- Back-to-back two 2-word frames, src_rdy_i held high -> 16 contiguous bytes, no gap cycle, correct SOF/EOF per frame.
- Random ll_dst_rdy (50%) on the first scenario's stimulus -> identical byte sequence; outputs unchanged during every stall cycle.
- Assert reset after byte 2 of a frame -> ll_src_rdy=0 immediately (async); after release dst_rdy_o=1, and the next SOF frame emits cleanly.
- With FIFO36_LL8_FRAMECHK_EN, send word without SOF from idle -> no bytes emitted, frame_err=1 and held until reset.

Source files
------------

// File: rtl/fifo36_pkg.sv
// Shared field layout of the 36-bit cascade-FIFO word and the last-byte-index helper.
package fifo36_pkg;

    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    localparam int OCC_LSB = 34;
    localparam int OCC_W   = 2;

    // Index of the final valid byte: full word unless this is an EOF word with non-zero occupancy.
    function automatic logic [1:0] occ_to_last(input logic eof, input logic [OCC_W-1:0] occ);
        logic [1:0] last_v;
        if (eof && (occ != 2'd0)) begin
            last_v = occ - 2'd1;
        end else begin
            last_v = 2'd3;
        end
        return last_v;
    endfunction

endpackage

// File: rtl/m_fifo36_to_ll8.sv
// 36-bit FIFO word to 8-bit byte-serial framed stream; one-word hold, 1 byte/clk sustained.
// Optional framing checker enabled by defining FIFO36_LL8_FRAMECHK_EN.
module m_fifo36_to_ll8
    import fifo36_pkg::*;
#(
    parameter bit BYTE_ORDER_BE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [35:0] datain,
    input  logic        src_rdy_i,
    output logic        dst_rdy_o,
    output logic [7:0]  ll_data,
    output logic        ll_sof,
    output logic        ll_eof,
    output logic        ll_src_rdy,
    input  logic        ll_dst_rdy,
    output logic        frame_err
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]  state_r;
    // Occupancy is folded into lst_r at capture, so only data, SOF and EOF are held.
    logic [33:0] hold_r;
    logic [1:0]  idx_r;
    logic [1:0]  lst_r;

    logic        full_s;
    logic        last_byte_s;
    logic        dst_rdy_s;
    logic        word_xfer_s;
    logic        byte_xfer_s;
    logic        keep_word_s;
    logic [1:0]  sel_s;
    logic [7:0]  byte_s;

    // Handshake decode and byte-lane selection for the held word.
    always_comb begin
        full_s      = (state_r == ST_FULL);
        last_byte_s = full_s && (idx_r == lst_r);
        dst_rdy_s   = !full_s || (ll_dst_rdy && last_byte_s);
        word_xfer_s = src_rdy_i && dst_rdy_s;
        byte_xfer_s = full_s && ll_dst_rdy;
        if (BYTE_ORDER_BE) begin
            sel_s = 2'd3 - idx_r;
        end else begin
            sel_s = idx_r;
        end
        case (sel_s)
            2'd0:    byte_s = hold_r[7:0];
            2'd1:    byte_s = hold_r[15:8];
            2'd2:    byte_s = hold_r[23:16];
            2'd3:    byte_s = hold_r[31:24];
            default: byte_s = 8'h00;
        endcase
    end

`ifdef FIFO36_LL8_FRAMECHK_EN
    logic in_frame_r;
    logic frame_err_r;

    // A continuation word arriving outside a frame is consumed without being emitted.
    always_comb begin
        keep_word_s = datain[SOF_BIT] || in_frame_r;
    end

    // Frame tracking and sticky error; a SOF+EOF word leaves the stream out of frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_frame_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else if (word_xfer_s) begin
            if (datain[SOF_BIT] == in_frame_r) begin
                frame_err_r <= 1'b1;
            end
            if (datain[SOF_BIT]) begin
                in_frame_r <= !datain[EOF_BIT];
            end else begin
                in_frame_r <= in_frame_r && !datain[EOF_BIT];
            end
        end
    end

    assign frame_err = frame_err_r;
`else
    always_comb begin
        keep_word_s = 1'b1;
    end

    assign frame_err = 1'b0;
`endif

    // Hold register and EMPTY/FULL state; a word landing on the last byte reloads with no bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_EMPTY;
            hold_r  <= 34'h0;
            idx_r   <= 2'd0;
            lst_r   <= 2'd3;
        end else if (word_xfer_s && keep_word_s) begin
            state_r <= ST_FULL;
            hold_r  <= datain[33:0];
            idx_r   <= 2'd0;
            lst_r   <= occ_to_last(datain[EOF_BIT], datain[OCC_LSB +: OCC_W]);
        end else if (word_xfer_s) begin
            state_r <= ST_EMPTY;
        end else if (byte_xfer_s) begin
            if (last_byte_s) begin
                state_r <= ST_EMPTY;
            end else begin
                idx_r <= idx_r + 2'd1;
            end
        end
    end

    assign dst_rdy_o  = dst_rdy_s;
    assign ll_src_rdy = full_s;
    assign ll_data    = full_s ? byte_s : 8'h00;
    assign ll_sof     = full_s && hold_r[SOF_BIT] && (idx_r == 2'd0);
    assign ll_eof     = last_byte_s && hold_r[EOF_BIT];

endmodule

// File: tb/tb_m_fifo36_to_ll8.sv
// Randomised self-checking bench for m_fifo36_to_ll8 against a queue-based byte model.
module tb_m_fifo36_to_ll8;

    logic        clk;
    logic        reset;
    logic [35:0] datain;
    logic        src_rdy_i;
    logic        dst_rdy_o;
    logic [7:0]  ll_data;
    logic        ll_sof;
    logic        ll_eof;
    logic        ll_src_rdy;
    logic        ll_dst_rdy;
    logic        frame_err;

    int checks = 0;
    int passes = 0;

    logic [35:0] in_q[$];
    logic [9:0]  exp_q[$];
    logic [7:0]  dst_hist;

    m_fifo36_to_ll8 #(.BYTE_ORDER_BE(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .datain     (datain),
        .src_rdy_i  (src_rdy_i),
        .dst_rdy_o  (dst_rdy_o),
        .ll_data    (ll_data),
        .ll_sof     (ll_sof),
        .ll_eof     (ll_eof),
        .ll_src_rdy (ll_src_rdy),
        .ll_dst_rdy (ll_dst_rdy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a word yields 4 bytes, or occ bytes when it carries EOF with occ != 0.
    function automatic void model_word(input logic [35:0] w);
        int n;
        logic [7:0] b;
        n = (w[33] && (w[35:34] != 2'd0)) ? int'(w[35:34]) : 4;
        for (int k = 0; k < n; k++) begin
            b = 8'(w[31:0] >> (24 - 8 * k));
            exp_q.push_back({w[32] && (k == 0), w[33] && (k == n - 1), b});
        end
    endfunction

    function automatic void send_word(input logic [35:0] w);
        in_q.push_back(w);
        model_word(w);
    endfunction

    task automatic drive_inputs(input int stall_pct);
        src_rdy_i  = (in_q.size() != 0);
        datain     = src_rdy_i ? in_q[0] : 36'h0;
        ll_dst_rdy = ($urandom_range(99) >= stall_pct);
    endtask

    task automatic run_stream(input int stall_pct, input string name);
        int cyc = 0;
        int first = -1;
        int last = -1;
        int nbytes = 0;
        logic stalled = 1'b0;
        logic acc;
        logic [9:0] held = 10'h0;
        logic [9:0] obs;
        logic [9:0] e;
        dst_hist = 8'h00;
        @(posedge clk); #1;
        drive_inputs(stall_pct);
        while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 2000) begin
            @(negedge clk);
            obs = {ll_sof, ll_eof, ll_data};
            if (cyc < 8) dst_hist[cyc] = dst_rdy_o;
            if (stalled) begin
                checks++;
                if (!ll_src_rdy || obs !== held)
                    $display("FAIL %s stall_hold: got rdy=%b %h required rdy=1 %h", name, ll_src_rdy, obs, held);
                else passes++;
            end
            if (ll_src_rdy && ll_dst_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL %s extra_byte: got %h required none", name, obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("FAIL %s byte: got %h required %h", name, obs, e);
                    else passes++;
                end
                if (first < 0) first = cyc;
                last = cyc;
                nbytes++;
            end
            stalled = ll_src_rdy && !ll_dst_rdy;
            held    = obs;
            acc     = src_rdy_i && dst_rdy_o;
            @(posedge clk); #1;
            if (acc) void'(in_q.pop_front());
            drive_inputs(stall_pct);
            cyc++;
        end
        src_rdy_i  = 1'b0;
        datain     = 36'h0;
        ll_dst_rdy = 1'b1;
        checks++;
        if (cyc >= 2000) begin
            $display("FAIL %s timeout: got %0d bytes left required 0", name, exp_q.size());
            exp_q.delete();
            in_q.delete();
        end else passes++;
        @(negedge clk);
        checks++;
        if (ll_src_rdy !== 1'b0) $display("FAIL %s drained: got ll_src_rdy=%b required 0", name, ll_src_rdy);
        else passes++;
        if (stall_pct == 0 && nbytes > 0) begin
            checks++;
            if (last - first + 1 != nbytes)
                $display("FAIL %s no_gap: got span %0d required %0d", name, last - first + 1, nbytes);
            else passes++;
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({ll_src_rdy, ll_sof, ll_eof, ll_data, dst_rdy_o} !== {3'b000, 8'h00, 1'b1})
            $display("FAIL %s idle: got rdy=%b sof=%b eof=%b data=%h dst=%b required 0 0 0 00 1",
                     name, ll_src_rdy, ll_sof, ll_eof, ll_data, dst_rdy_o);
        else passes++;
    endtask

    task automatic test_reset();
        reset = 1'b0; src_rdy_i = 1'b0; datain = 36'h0; ll_dst_rdy = 1'b1;
        #12;
        check_idle_outputs("reset_held");
        checks++;
        if (frame_err !== 1'b0) $display("FAIL reset frame_err: got %b required 0", frame_err);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_single_frame();
        send_word(36'h1_11223344);
        send_word(36'h2_55667788);
        run_stream(0, "single_frame");
        checks++;
        if (dst_hist !== 8'b0001_0001) $display("FAIL single_frame dst_rdy_pattern: got %b required 00010001", dst_hist);
        else passes++;
    endtask

    task automatic test_single_byte();
        send_word(36'h7_AABBCCDD);
        run_stream(0, "single_byte");
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 2; f++) begin
            send_word({4'h1, $urandom()});
            send_word({4'h2, $urandom()});
        end
        run_stream(0, "back_to_back");
    endtask

    task automatic test_stall();
        send_word(36'h1_11223344);
        send_word(36'h2_55667788);
        run_stream(50, "stall");
    endtask

    task automatic test_random_frames();
        int nw;
        logic [1:0] occ;
        for (int f = 0; f < 8; f++) begin
            nw  = $urandom_range(1, 4);
            occ = 2'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                send_word({(w == nw - 1) ? occ : 2'($urandom_range(0, 3)),
                           (w == nw - 1), (w == 0), $urandom()});
            end
        end
        run_stream(50, "random_frames");
    endtask

    task automatic test_reset_mid_frame();
        @(posedge clk); #1;
        src_rdy_i = 1'b1; datain = 36'h1_11223344; ll_dst_rdy = 1'b1;
        @(posedge clk); #1;
        src_rdy_i = 1'b0; datain = 36'h0;
        @(posedge clk);
        @(posedge clk); #3;
        checks++;
        if (ll_data !== 8'h33 || ll_src_rdy !== 1'b1)
            $display("FAIL reset_mid pre: got rdy=%b data=%h required 1 33", ll_src_rdy, ll_data);
        else passes++;
        reset = 1'b0;
        #1;
        checks++;
        if ({ll_src_rdy, ll_sof, ll_eof, ll_data} !== 11'h0)
            $display("FAIL reset_mid async: got rdy=%b sof=%b eof=%b data=%h required 0 0 0 00",
                     ll_src_rdy, ll_sof, ll_eof, ll_data);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_mid_release");
        send_word(36'h1_CAFEF00D);
        send_word(36'h6_12345678);
        run_stream(0, "reset_mid_next");
    endtask

`ifdef FIFO36_LL8_FRAMECHK_EN
    task automatic test_framechk();
        in_q.push_back(36'h0_DEADBEEF);
        run_stream(0, "framechk_drop");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (ll_src_rdy !== 1'b0 || frame_err !== 1'b1)
                $display("FAIL framechk idle: got rdy=%b err=%b required 0 1", ll_src_rdy, frame_err);
            else passes++;
        end
        send_word(36'h1_01020304);
        send_word(36'hA_05060708);
        run_stream(25, "framechk_after");
        checks++;
        if (frame_err !== 1'b1) $display("FAIL framechk sticky: got %b required 1", frame_err);
        else passes++;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) $display("FAIL framechk cleared: got %b required 0", frame_err);
        else passes++;
    endtask
`else
    task automatic test_framechk();
        in_q.push_back(36'h0_DEADBEEF);
        model_word(36'h0_DEADBEEF);
        run_stream(0, "no_framechk");
        checks++;
        if (frame_err !== 1'b0) $display("FAIL no_framechk frame_err: got %b required 0", frame_err);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_single_byte();
        test_back_to_back();
        test_stall();
        test_random_frames();
        test_reset_mid_frame();
        test_framechk();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
